// File: rtl/mc_sequencer_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// The sequencer (master) reads the latched instruction and ALU flags and drives every select and enable.
interface mc_sequencer_if;
  logic [31:0] instr;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_ltu;
  logic        pc_write;
  logic        adr_src;
  logic        mem_write;
  logic        ir_write;
  logic [1:0]  result_src;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  alu_control;
  logic [2:0]  imm_src;
  logic        reg_write;
  logic        instr_retired;
  logic        illegal;

  modport master (
    input  instr, alu_zero, alu_lt, alu_ltu,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_control, imm_src, reg_write, instr_retired, illegal
  );

  modport slave (
    output instr, alu_zero, alu_lt, alu_ltu,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_control, imm_src, reg_write, instr_retired, illegal
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multicycle RV32I control FSM: one state per cycle, Moore decode of selects/enables from state and instr,
// with the branch pc_write as the single Mealy output.
module mc_sequencer (
  input  logic           clk,
  input  logic           reset,
  mc_sequencer_if.master bus
);
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR = 4'b0011,
                         ALU_XOR = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111,
                         ALU_SLT = 4'b1000, ALU_SLTU = 4'b1001, ALU_PASSB = 4'b1010;
  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_U = 3'b011, IMM_J = 3'b100;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH_A, FETCH, DECODE, MEMADR, MEMREAD, MEMWAIT, MEMWB, MEMWRITE,
    EXEC_R, EXEC_I, EXEC_U, ALUWB, BRANCH, JALR_ADR, JAL, ILLEGAL
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_b5;
  logic       w_br_bad;
  logic       w_unused;

  assign w_op     = bus.instr[6:0];
  assign w_f3     = bus.instr[14:12];
  assign w_b5     = bus.instr[30];
  assign w_br_bad = (w_f3 == 3'b010) || (w_f3 == 3'b011);
  assign w_unused = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH_A:  w_next = FETCH;
      FETCH:    w_next = DECODE;
      DECODE: begin
        case (w_op)
          OP_LOAD, OP_STORE: w_next = MEMADR;
          OP_R:              w_next = EXEC_R;
          OP_I:              w_next = EXEC_I;
          OP_LUI, OP_AUIPC:  w_next = EXEC_U;
          OP_BR:             w_next = BRANCH;
          OP_JAL:            w_next = JAL;
          OP_JALR:           w_next = JALR_ADR;
          default:           w_next = ILLEGAL;
        endcase
      end
      MEMADR:   w_next = (w_op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:  w_next = MEMWAIT;
      MEMWAIT:  w_next = MEMWB;
      MEMWB:    w_next = FETCH_A;
      MEMWRITE: w_next = FETCH_A;
      EXEC_R:   w_next = ALUWB;
      EXEC_I:   w_next = ALUWB;
      EXEC_U:   w_next = ALUWB;
      ALUWB:    w_next = FETCH_A;
      BRANCH:   w_next = w_br_bad ? ILLEGAL : FETCH_A;
      JALR_ADR: w_next = JAL;
      JAL:      w_next = ALUWB;
      default:  w_next = ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= FETCH_A;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ILLEGAL) r_illegal <= 1'b1;
    end
  end

  // Outputs decode from the state register, so an asynchronous reset drops every enable at once.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.adr_src       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.result_src    = 2'b00;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_control   = ALU_ADD;
    bus.imm_src       = IMM_I;
    bus.reg_write     = 1'b0;
    bus.instr_retired = 1'b0;
    bus.illegal       = r_illegal;
    case (r_state)
      FETCH: begin
        bus.ir_write   = 1'b1;
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        bus.pc_write   = 1'b1;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (w_op == OP_BR) ? IMM_B : (w_op == OP_JAL) ? IMM_J : IMM_I;
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (w_op == OP_STORE) ? IMM_S : IMM_I;
      end
      MEMREAD, MEMWAIT: bus.adr_src = 1'b1;
      MEMWB: begin
        bus.result_src    = 2'b01;
        bus.reg_write     = 1'b1;
        bus.instr_retired = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src       = 1'b1;
        bus.mem_write     = 1'b1;
        bus.instr_retired = 1'b1;
      end
      EXEC_R: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_control = alu_dec(w_f3, w_b5, 1'b1);
      end
      EXEC_I: begin
        bus.alu_src_a   = 2'b10;
        bus.alu_src_b   = 2'b01;
        bus.alu_control = alu_dec(w_f3, w_b5, 1'b0);
      end
      EXEC_U: begin
        bus.imm_src     = IMM_U;
        bus.alu_src_b   = 2'b01;
        bus.alu_src_a   = (w_op == OP_LUI) ? 2'b00 : 2'b01;
        bus.alu_control = (w_op == OP_LUI) ? ALU_PASSB : ALU_ADD;
      end
      ALUWB: begin
        bus.reg_write     = 1'b1;
        bus.instr_retired = 1'b1;
      end
      BRANCH: begin
        // An unsupported funct3 is not a completed instruction, so it neither retires nor writes PC.
        bus.alu_src_a     = 2'b10;
        bus.alu_control   = ALU_SUB;
        bus.instr_retired = !w_br_bad;
        bus.pc_write      = br_taken(w_f3, bus.alu_zero, bus.alu_lt, bus.alu_ltu);
      end
      JALR_ADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
      end
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        bus.pc_write  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
